// File: rtl/dataset_shuffle_reader.sv
// rtl/dataset_shuffle_reader.sv - epoch reader emitting each sample index once in LFSR-shuffled order
// Optional seed input port enabled by defining DSR_SEED_PORT_EN.
module dataset_shuffle_reader #(
  parameter int          ADDR_W = 8,
  parameter int          DATA_W = 32,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   n_samples,
`ifdef DSR_SEED_PORT_EN
  input  logic [15:0]       seed,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last
);

  localparam int          DEPTH   = 1 << ADDR_W;
  localparam logic [15:0] SEED_NZ = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [2:0] {IDLE, INIT, PICK, READ, WAIT, SEND, DONE} state_t;
  state_t state, state_next;

  logic [ADDR_W-1:0] idx_tbl [DEPTH];
  logic [ADDR_W:0]   n_lat, k, remaining, rem_m1;
  logic [ADDR_W-1:0] idx, mask, cand;
  logic [15:0]       lfsr, lfsr_step;
  logic              accept;
  logic              tbl_we;
  logic [ADDR_W-1:0] tbl_waddr, tbl_wdata;

  // Candidate draw: mask the LFSR down to the smallest power-of-two range covering remaining-1.
  always_comb begin
    rem_m1 = remaining - 1'b1;
    mask   = '0;
    for (int i = 0; i < ADDR_W; i++) mask[i] = |(rem_m1 >> i);
    cand      = lfsr[ADDR_W-1:0] & mask;
    accept    = ({1'b0, cand} < remaining);
    lfsr_step = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start) state_next = (n_samples == '0) ? DONE : INIT;
      INIT: if (k == n_lat - 1'b1) state_next = PICK;
      PICK: if (accept) state_next = READ;
      READ: state_next = WAIT;
      WAIT: state_next = SEND;
      SEND: if (out_ready) state_next = (remaining == '0) ? DONE : PICK;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    tbl_we    = 1'b0;
    tbl_waddr = k[ADDR_W-1:0];
    tbl_wdata = k[ADDR_W-1:0];
    if (state == INIT) begin
      tbl_we = 1'b1;
    end else if (state == PICK && accept) begin
      // Swap-remove: the last live entry fills the hole left by the drawn one.
      tbl_we    = 1'b1;
      tbl_waddr = cand;
      tbl_wdata = idx_tbl[rem_m1[ADDR_W-1:0]];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && tbl_we) idx_tbl[tbl_waddr] <= tbl_wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      n_lat     <= '0;
      k         <= '0;
      remaining <= '0;
      idx       <= '0;
      lfsr      <= SEED_NZ;
      out_data  <= '0;
      out_index <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: if (start) begin
          n_lat <= n_samples;
          k     <= '0;
`ifdef DSR_SEED_PORT_EN
          lfsr  <= (seed == 16'h0000) ? 16'h0001 : seed;
`endif
        end
        INIT: begin
          k <= k + 1'b1;
          if (k == n_lat - 1'b1) remaining <= n_lat;
        end
        PICK: begin
          lfsr <= lfsr_step;
          if (accept) begin
            idx       <= idx_tbl[cand];
            remaining <= remaining - 1'b1;
          end
        end
        WAIT: begin
          out_data  <= mem_rd_data;
          out_index <= idx;
        end
        default: ;
      endcase
    end
  end

  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign mem_rd_en = (state == READ);
  assign mem_addr  = idx;
  assign out_valid = (state == SEND);
  assign out_last  = out_valid && (remaining == '0);

endmodule

// File: tb/tb_dataset_shuffle_reader.sv
// tb/tb_dataset_shuffle_reader.sv - directed self-checking bench for dataset_shuffle_reader
module tb_dataset_shuffle_reader;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst, start, out_ready;
  logic [ADDR_W:0]   n_samples;
  logic              busy, done, mem_rd_en, out_valid, out_last;
  logic [ADDR_W-1:0] mem_addr, out_index;
  logic [DATA_W-1:0] mem_rd_data = '0;
  logic [DATA_W-1:0] out_data;
`ifdef DSR_SEED_PORT_EN
  logic [15:0]       seed = 16'h0000;
`endif

  int errors = 0;
  int checks = 0;
  int order[$];
  int exp_order[$];

  dataset_shuffle_reader #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst(rst), .start(start), .n_samples(n_samples),
`ifdef DSR_SEED_PORT_EN
    .seed(seed),
`endif
    .busy(busy), .done(done), .mem_rd_en(mem_rd_en), .mem_addr(mem_addr),
    .mem_rd_data(mem_rd_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_index(out_index), .out_last(out_last)
  );

  always #5 clk = ~clk;

  // Sample memory: word[i] = i + 100, one-cycle read latency.
  always @(posedge clk) if (mem_rd_en) mem_rd_data <= DATA_W'(mem_addr) + 100;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, mem_rd_en, 0);
    chk({tag, "_addr"}, mem_addr, 0);
    chk({tag, "_valid"}, out_valid, 0);
    chk({tag, "_last"}, out_last, 0);
    chk({tag, "_data"}, out_data, 0);
    chk({tag, "_index"}, out_index, 0);
  endtask

  task automatic run_epoch(input int n, input int stall, input int abort_after);
    bit                seen [256];
    int                xfers = 0, dones = 0, stall_left = stall;
    bit                held = 0, post_check = 0, finished = 0, quiet = 1;
    logic [DATA_W-1:0] hd;
    logic [ADDR_W-1:0] hi;
    logic              hl;
    foreach (seen[i]) seen[i] = 0;
    order.delete();
    @(negedge clk); start = 1; n_samples = (ADDR_W+1)'(n);
    @(negedge clk); start = 0;
    for (int cyc = 1; cyc <= 20000 && !finished; cyc++) begin
      if (post_check) begin chk("xfer_on_first_ready", out_valid, 0); post_check = 0; end
      if (mem_rd_en) chk("addr_range", mem_addr < n, 1);
      if (n == 0) chk("zero_no_activity", mem_rd_en | out_valid, 0);
      if (out_valid) begin
        if (stall_left > 0) begin
          if (!held) begin held = 1; hd = out_data; hi = out_index; hl = out_last; end
          else begin
            chk("stall_data", out_data, hd);
            chk("stall_index", out_index, hi);
            chk("stall_last", out_last, hl);
          end
          chk("stall_no_rd", mem_rd_en, 0);
          out_ready = 0;
          stall_left--;
        end else begin
          out_ready = 1;
          if (held) begin
            chk("release_data", out_data, hd);
            chk("release_index", out_index, hi);
            held = 0; post_check = 1;
          end
          chk("data", out_data, out_index + 100);
          chk("last", out_last, (xfers + 1 == n));
          chk("unique", seen[out_index], 0);
          seen[out_index] = 1;
          if (xfers < exp_order.size()) chk("order", out_index, exp_order[xfers]);
          order.push_back(int'(out_index));
          xfers++;
          if (xfers == abort_after) finished = 1;
        end
      end
      if (done) begin
        dones++;
        chk("done_after_last", xfers, n);
        if (n == 0) chk("zero_latency", cyc <= 2, 1);
        finished = 1;
      end
      if (!finished) @(negedge clk);
    end
    if (!finished) chk("epoch_timeout", 0, 1);
    out_ready = 1;
    if (abort_after > 0 && xfers == abort_after) begin
      @(negedge clk); rst = 1;
      @(negedge clk); check_reset_outputs("abort");
      rst = 0;
      repeat (15) begin
        @(negedge clk);
        if (done || mem_rd_en || out_valid) quiet = 0;
      end
      chk("abort_quiet", quiet, 1);
    end else if (finished) begin
      @(negedge clk);
      chk("done_one_cycle", done, 0);
      chk("idle_after", busy, 0);
      chk("done_count", dones, 1);
      chk("xfer_count", xfers, n);
    end
  endtask

  initial begin
`ifdef DSR_SEED_PORT_EN
    int q1[$];
`endif
    rst = 1; start = 0; n_samples = '0; out_ready = 1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 0;

    // From seed 16'hACE1 the five draws accept immediately: 1,0,3,2,4.
    exp_order = '{1, 0, 3, 2, 4};
    run_epoch(5, 0, 0);
    exp_order.delete();

    run_epoch(0, 0, 0);
    run_epoch(4, 10, 0);
    run_epoch(256, 0, 0);
    run_epoch(8, 0, 2);
    run_epoch(8, 0, 0);

`ifdef DSR_SEED_PORT_EN
    seed = 16'h1234;
    run_epoch(8, 0, 0); q1 = order;
    run_epoch(8, 0, 0);
    for (int i = 0; i < 8; i++) chk("seed_repeat", order[i], q1[i]);
    seed = 16'h0001;
    run_epoch(8, 0, 0); q1 = order;
    seed = 16'h0000;
    run_epoch(8, 0, 0);
    for (int i = 0; i < 8; i++) chk("seed_zero", order[i], q1[i]);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
